// File: rtl/dco_code_mapper.sv
// Maps a signed IW.FRAC tuning word onto NBANK signed DCO bank codes.
// Fractional bits are dithered onto the fine bank; coarse banks retarget with lockout and saturation.
module dco_code_mapper #(
    parameter int NBANK = 4,
    parameter int CW    = 8,
    parameter int IW    = 20,
    parameter int FRAC  = 8,
    parameter int RATIO = 16,
    parameter int HI    = 64,
    parameter int LO    = -64,
    parameter int HOLD  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tw_valid,
    input  logic [IW+FRAC-1:0]    tw,
    output logic [NBANK*CW-1:0]   ctrl,
    output logic                  ctrl_valid,
    output logic                  retarget,
    output logic                  sat_hi,
    output logic                  sat_lo,
    input  logic                  clr_sat
);

    localparam int FW  = IW + CW * NBANK;
    localparam int J   = NBANK - 2;
    localparam int LKW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [CW-1:0] CMAX_C = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] CMIN_C = {1'b1, {(CW-1){1'b0}}};
    localparam logic signed [FW-1:0] CMAX_F = FW'($signed(CMAX_C));
    localparam logic signed [FW-1:0] CMIN_F = FW'($signed(CMIN_C));
    localparam logic signed [FW-1:0] HI_F   = FW'(HI);
    localparam logic signed [FW-1:0] LO_F   = FW'(LO);

    // Weight of bank k expressed in fine-bank LSBs.
    function automatic logic signed [FW-1:0] weight(input int k);
        logic signed [FW-1:0] w;
        w = FW'(1);
        for (int i = 0; i < NBANK - 1 - k; i++) begin
            w = w * FW'(RATIO);
        end
        return w;
    endfunction

    localparam logic signed [FW-1:0] W_J = weight(J);

    logic [NBANK-1:0][CW-1:0] ctrl_r;
    logic [FRAC-1:0]          acc_r;
    logic [LKW-1:0]           lk_r;
    logic                     ctrl_valid_r;
    logic                     retarget_r;
    logic                     sat_hi_r;
    logic                     sat_lo_r;

    logic [FRAC:0]            acc_sum_s;
    logic signed [FW-1:0]     coarse_sum_s;
    logic signed [FW-1:0]     fine_s;
    logic signed [FW-1:0]     fine_out_s;
    logic [J:0][CW-1:0]       coarse_next_s;
    logic [CW-1:0]            fine_code_s;
    logic                     up_req_s;
    logic                     dn_req_s;
    logic                     up_ok_s;
    logic                     dn_ok_s;
    logic                     do_up_s;
    logic                     do_dn_s;
    logic                     clamp_hi_s;
    logic                     clamp_lo_s;
    logic                     set_hi_s;
    logic                     set_lo_s;
    int                       up_k_s;
    int                       dn_k_s;

    // Next-state datapath: dither, fine residue, retarget selection and clamp.
    always_comb begin
        acc_sum_s    = {1'b0, acc_r} + {1'b0, tw[FRAC-1:0]};
        coarse_sum_s = '0;
        for (int k = 0; k <= J; k++) begin
            coarse_sum_s = coarse_sum_s + FW'($signed(ctrl_r[k])) * weight(k);
        end
        fine_s = FW'($signed(tw[IW+FRAC-1:FRAC]))
               + $signed({{(FW-1){1'b0}}, acc_sum_s[FRAC]}) - coarse_sum_s;

        // Ascending scan leaves the highest-index movable bank selected.
        up_ok_s = 1'b0;
        dn_ok_s = 1'b0;
        up_k_s  = 0;
        dn_k_s  = 0;
        for (int k = 0; k <= J; k++) begin
            up_ok_s = up_ok_s | (ctrl_r[k] != CMAX_C);
            up_k_s  = (ctrl_r[k] != CMAX_C) ? k : up_k_s;
            dn_ok_s = dn_ok_s | (ctrl_r[k] != CMIN_C);
            dn_k_s  = (ctrl_r[k] != CMIN_C) ? k : dn_k_s;
        end

        up_req_s = (fine_s > HI_F) && (lk_r == '0);
        dn_req_s = (fine_s < LO_F) && (lk_r == '0);
        do_up_s  = up_req_s && up_ok_s;
        do_dn_s  = dn_req_s && dn_ok_s;

        for (int k = 0; k <= J; k++) begin
            if (do_up_s && (k == up_k_s)) begin
                coarse_next_s[k] = ctrl_r[k] + CW'(1);
            end else if (do_up_s && (k > up_k_s)) begin
                coarse_next_s[k] = ctrl_r[k] - CW'(RATIO - 1);
            end else if (do_dn_s && (k == dn_k_s)) begin
                coarse_next_s[k] = ctrl_r[k] - CW'(1);
            end else if (do_dn_s && (k > dn_k_s)) begin
                coarse_next_s[k] = ctrl_r[k] + CW'(RATIO - 1);
            end else begin
                coarse_next_s[k] = ctrl_r[k];
            end
        end

        if (do_up_s) begin
            fine_out_s = fine_s - W_J;
        end else if (do_dn_s) begin
            fine_out_s = fine_s + W_J;
        end else begin
            fine_out_s = fine_s;
        end

        clamp_hi_s = fine_out_s > CMAX_F;
        clamp_lo_s = fine_out_s < CMIN_F;
        if (clamp_hi_s) begin
            fine_code_s = CMAX_C;
        end else if (clamp_lo_s) begin
            fine_code_s = CMIN_C;
        end else begin
            fine_code_s = fine_out_s[CW-1:0];
        end

        set_hi_s = (up_req_s && !up_ok_s) || clamp_hi_s;
        set_lo_s = (dn_req_s && !dn_ok_s) || clamp_lo_s;
    end

    // State and registered outputs; lockout counts down regardless of tw_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r       <= '0;
            acc_r        <= '0;
            lk_r         <= '0;
            ctrl_valid_r <= 1'b0;
            retarget_r   <= 1'b0;
            sat_hi_r     <= 1'b0;
            sat_lo_r     <= 1'b0;
        end else begin
            lk_r <= (lk_r != '0) ? lk_r - LKW'(1) : lk_r;
            if (tw_valid) begin
                acc_r <= acc_sum_s[FRAC-1:0];
                for (int k = 0; k <= J; k++) begin
                    ctrl_r[k] <= coarse_next_s[k];
                end
                ctrl_r[NBANK-1] <= fine_code_s;
                ctrl_valid_r    <= 1'b1;
                retarget_r      <= do_up_s || do_dn_s;
                if (do_up_s || do_dn_s) begin
                    lk_r <= LKW'(HOLD);
                end else begin
                    lk_r <= (lk_r != '0) ? lk_r - LKW'(1) : lk_r;
                end
                sat_hi_r <= set_hi_s | (sat_hi_r & ~clr_sat);
                sat_lo_r <= set_lo_s | (sat_lo_r & ~clr_sat);
            end else begin
                ctrl_valid_r <= 1'b0;
                retarget_r   <= 1'b0;
                sat_hi_r     <= sat_hi_r & ~clr_sat;
                sat_lo_r     <= sat_lo_r & ~clr_sat;
            end
        end
    end

    assign ctrl       = ctrl_r;
    assign ctrl_valid = ctrl_valid_r;
    assign retarget   = retarget_r;
    assign sat_hi     = sat_hi_r;
    assign sat_lo     = sat_lo_r;

endmodule

// File: tb/tb_dco_code_mapper.sv
// Self-checking bench: a 4-bank and a 2-bank mapper share stimulus and are compared
// every cycle against an integer reference model, plus directed expectations.
module tb_dco_code_mapper;

    logic        clk = 1'b0;
    logic        reset;
    logic        tw_valid;
    logic        clr_sat;
    logic [27:0] tw;
    logic [31:0] ctrl_a;
    logic [15:0] ctrl_b;
    logic        cv_a, rt_a, sh_a, sl_a;
    logic        cv_b, rt_b, sh_b, sl_b;
    int          compared   = 0;
    int          mismatched = 0;

    dco_code_mapper dut_a (
        .clk(clk), .reset(reset), .tw_valid(tw_valid), .tw(tw), .ctrl(ctrl_a),
        .ctrl_valid(cv_a), .retarget(rt_a), .sat_hi(sh_a), .sat_lo(sl_a), .clr_sat(clr_sat)
    );

    dco_code_mapper #(.NBANK(2)) dut_b (
        .clk(clk), .reset(reset), .tw_valid(tw_valid), .tw(tw), .ctrl(ctrl_b),
        .ctrl_valid(cv_b), .retarget(rt_b), .sat_hi(sh_b), .sat_lo(sl_b), .clr_sat(clr_sat)
    );

    always #5 clk = ~clk;

    // Reference model state, one slot per instance.
    int     nbank[2] = '{4, 2};
    int     mc[2][3];
    int     mfine[2];
    int     macc[2];
    int     mlk[2];
    bit     mval[2], mret[2], mshi[2], mslo[2], mclamp[2];
    longint mtarget[2];

    function automatic longint wgt(input int nb, input int k);
        longint w;
        w = 1;
        for (int i = 0; i < nb - 1 - k; i++) w = w * 16;
        return w;
    endfunction

    function automatic logic [27:0] tw_of(input int ip, input int fp);
        return {20'(ip), 8'(fp)};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 3; k++) mc[u][k] = 0;
            mfine[u] = 0; macc[u] = 0; mlk[u] = 0;
            mval[u] = 0; mret[u] = 0; mshi[u] = 0; mslo[u] = 0; mclamp[u] = 0;
            mtarget[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input bit v, input logic [27:0] twv, input bit clr);
        int     j, k, lk_now, asum;
        longint fine, s;
        bit     carry, set_hi, set_lo;
        lk_now = mlk[u];
        if (mlk[u] > 0) mlk[u] = mlk[u] - 1;
        if (!v) begin
            mval[u] = 0; mret[u] = 0;
            if (clr) begin mshi[u] = 0; mslo[u] = 0; end
            return;
        end
        asum    = macc[u] + int'(twv[7:0]);
        carry   = (asum >= 256);
        macc[u] = asum % 256;
        mtarget[u] = longint'($signed(twv[27:8])) + longint'(carry);
        s = 0;
        for (int b = 0; b < nbank[u] - 1; b++) s = s + longint'(mc[u][b]) * wgt(nbank[u], b);
        fine = mtarget[u] - s;
        j = nbank[u] - 2;
        set_hi = 0; set_lo = 0; mret[u] = 0;
        if (lk_now == 0 && fine > 64) begin
            k = j;
            while (k >= 0 && mc[u][k] == 127) k--;
            if (k < 0) set_hi = 1;
            else begin
                mc[u][k]++;
                for (int m = k + 1; m <= j; m++) mc[u][m] -= 15;
                fine = fine - 16; mret[u] = 1; mlk[u] = 4;
            end
        end else if (lk_now == 0 && fine < -64) begin
            k = j;
            while (k >= 0 && mc[u][k] == -128) k--;
            if (k < 0) set_lo = 1;
            else begin
                mc[u][k]--;
                for (int m = k + 1; m <= j; m++) mc[u][m] += 15;
                fine = fine + 16; mret[u] = 1; mlk[u] = 4;
            end
        end
        mclamp[u] = (fine > 127) || (fine < -128);
        if (fine > 127) begin mfine[u] = 127; set_hi = 1; end
        else if (fine < -128) begin mfine[u] = -128; set_lo = 1; end
        else mfine[u] = int'(fine);
        mshi[u] = set_hi | (mshi[u] & !clr);
        mslo[u] = set_lo | (mslo[u] & !clr);
        mval[u] = 1;
    endtask

    function automatic logic [35:0] exp_vec(input int u);
        logic [31:0] c;
        c = '0;
        for (int k = 0; k < nbank[u] - 1; k++) c[k*8 +: 8] = 8'(mc[u][k]);
        c[(nbank[u]-1)*8 +: 8] = 8'(mfine[u]);
        return {c, mval[u], mret[u], mshi[u], mslo[u]};
    endfunction

    function automatic logic [35:0] obs_a();
        return {ctrl_a, cv_a, rt_a, sh_a, sl_a};
    endfunction

    function automatic logic [35:0] obs_b();
        return {16'h0000, ctrl_b, cv_b, rt_b, sh_b, sl_b};
    endfunction

    function automatic longint dut_sum_a();
        longint s;
        s = 0;
        for (int k = 0; k < 4; k++) s = s + longint'($signed(ctrl_a[k*8 +: 8])) * wgt(4, k);
        return s;
    endfunction

    task automatic cycle(input bit v, input logic [27:0] t, input bit c);
        tw_valid = v; tw = t; clr_sat = c;
        @(posedge clk);
        model_step(0, v, t, c);
        model_step(1, v, t, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; tw_valid = 1'b0; clr_sat = 1'b0; tw = '0;
        @(negedge clk); @(negedge clk);
        compared++;
        if (obs_a() !== 36'h0) begin mismatched++; $display("FAIL reset_a: got %h want 0", obs_a()); end
        compared++;
        if (obs_b() !== 36'h0) begin mismatched++; $display("FAIL reset_b: got %h want 0", obs_b()); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        cycle(1'b1, tw_of(40, 0), 1'b0);
        compared++;
        if (obs_a() !== {32'h2800_0000, 4'b1000}) begin mismatched++; $display("FAIL basic40_a: got %h want %h", obs_a(), {32'h2800_0000, 4'b1000}); end
        compared++;
        if (obs_b() !== exp_vec(1)) begin mismatched++; $display("FAIL basic40_b: got %h want %h", obs_b(), exp_vec(1)); end
        cycle(1'b1, tw_of(70, 0), 1'b0);
        compared++;
        if (obs_a() !== {32'h3601_0000, 4'b1100}) begin mismatched++; $display("FAIL retarget70_a: got %h want %h", obs_a(), {32'h3601_0000, 4'b1100}); end
        compared++;
        if (obs_b() !== {16'h0, 16'h3601, 4'b1100}) begin mismatched++; $display("FAIL retarget70_b: got %h want %h", obs_b(), {16'h0, 16'h3601, 4'b1100}); end
        cycle(1'b1, tw_of(70, 0), 1'b0);
        compared++;
        if (obs_a() !== {32'h3601_0000, 4'b1000}) begin mismatched++; $display("FAIL lockout_a: got %h want %h", obs_a(), {32'h3601_0000, 4'b1000}); end
        cycle(1'b0, tw_of(0, 0), 1'b0);
        compared++;
        if (obs_a() !== exp_vec(0)) begin mismatched++; $display("FAIL hold_a: got %h want %h", obs_a(), exp_vec(0)); end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, tw_of(90, 0), 1'b0);
        tw_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        compared++;
        if (obs_a() !== 36'h0) begin mismatched++; $display("FAIL async_reset_a: got %h want 0", obs_a()); end
        compared++;
        if (obs_b() !== 36'h0) begin mismatched++; $display("FAIL async_reset_b: got %h want 0", obs_b()); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1'b1, tw_of(70, 0), 1'b0);
        compared++;
        if (obs_a() !== {32'h3601_0000, 4'b1100}) begin mismatched++; $display("FAIL cold_start_a: got %h want %h", obs_a(), {32'h3601_0000, 4'b1100}); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_dither();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, tw_of(10, 8'h40), 1'b0);
            want = (i % 4 == 3) ? 8'd11 : 8'd10;
            compared++;
            if (ctrl_a[31:24] !== want) begin mismatched++; $display("FAIL dither_%0d: got %0d want %0d", i, ctrl_a[31:24], want); end
            compared++;
            if (obs_b() !== exp_vec(1)) begin mismatched++; $display("FAIL dither_b_%0d: got %h want %h", i, obs_b(), exp_vec(1)); end
        end
    endtask

    task automatic test_carry_ramp();
        for (int i = 0; i < 640; i++) begin
            cycle(1'b1, tw_of(2092, 0), 1'b0);
            compared++;
            if (obs_a() !== exp_vec(0) || obs_b() !== exp_vec(1)) begin
                mismatched++;
                $display("FAIL ramp_%0d: got %h/%h want %h/%h", i, obs_a(), obs_b(), exp_vec(0), exp_vec(1));
            end
        end
        compared++;
        if (ctrl_a[23:16] !== 8'd127 || ctrl_b[7:0] !== 8'd127) begin mismatched++; $display("FAIL ramp_end: got %0d/%0d want 127", ctrl_a[23:16], ctrl_b[7:0]); end
        cycle(1'b1, tw_of(2092, 0), 1'b1);
        compared++;
        if ({sh_a, sh_b} !== 2'b00) begin mismatched++; $display("FAIL clr_sat_ramp: got %b want 00", {sh_a, sh_b}); end
        cycle(1'b1, tw_of(2102, 0), 1'b0);
        compared++;
        if (obs_a() !== {32'h3670_0100, 4'b1100}) begin mismatched++; $display("FAIL borrow_a: got %h want %h", obs_a(), {32'h3670_0100, 4'b1100}); end
        compared++;
        if (dut_sum_a() !== 64'sd2102) begin mismatched++; $display("FAIL borrow_invariant: got %0d want 2102", dut_sum_a()); end
        compared++;
        if (obs_b() !== {16'h0, 16'h467F, 4'b1010}) begin mismatched++; $display("FAIL nomove_b: got %h want %h", obs_b(), {16'h0, 16'h467F, 4'b1010}); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, tw_of(5000, 0), (i == 1));
            compared++;
            if (obs_b() !== {16'h0, 16'h7F7F, 4'b1010}) begin mismatched++; $display("FAIL sat_b_%0d: got %h want %h", i, obs_b(), {16'h0, 16'h7F7F, 4'b1010}); end
            compared++;
            if (obs_a() !== exp_vec(0)) begin mismatched++; $display("FAIL sat_a_%0d: got %h want %h", i, obs_a(), exp_vec(0)); end
        end
        cycle(1'b1, tw_of(2040, 0), 1'b1);
        compared++;
        if (obs_b() !== {16'h0, 16'h087F, 4'b1000}) begin mismatched++; $display("FAIL sat_clear_b: got %h want %h", obs_b(), {16'h0, 16'h087F, 4'b1000}); end
        compared++;
        if (obs_a() !== exp_vec(0)) begin mismatched++; $display("FAIL sat_clear_a: got %h want %h", obs_a(), exp_vec(0)); end
    endtask

    task automatic test_random();
        int center, ti, fr;
        bit v, c;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        center = 0;
        for (int i = 0; i < 800; i++) begin
            center = center + int'($urandom_range(0, 60)) - 30;
            if (center > 2600) center = 2600;
            if (center < -2600) center = -2600;
            ti = center + int'($urandom_range(0, 200)) - 100;
            fr = int'($urandom_range(0, 255));
            v  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 15) == 0);
            cycle(v, tw_of(ti, fr), c);
            compared++;
            if (obs_a() !== exp_vec(0)) begin mismatched++; $display("FAIL random_a_%0d: got %h want %h", i, obs_a(), exp_vec(0)); end
            compared++;
            if (obs_b() !== exp_vec(1)) begin mismatched++; $display("FAIL random_b_%0d: got %h want %h", i, obs_b(), exp_vec(1)); end
            if (v && !mclamp[0]) begin
                compared++;
                if (dut_sum_a() !== mtarget[0]) begin mismatched++; $display("FAIL invariant_%0d: got %0d want %0d", i, dut_sum_a(), mtarget[0]); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; tw_valid = 1'b0; clr_sat = 1'b0; tw = '0;
        model_reset();
        test_reset();
        test_basic();
        test_reset_midstream();
        test_dither();
        test_carry_ramp();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
